// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side bus bundle for the direct-mapped instruction cache.
interface icache_direct_if #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              flush;
    logic              iREN;
    logic [WORD_W-1:0] iaddr;
    logic              iwait;
    logic [WORD_W-1:0] iload;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  miss_count;

    // Cache side
    modport slave (
        input  imemREN, imemaddr, flush, iwait, iload,
        output ihit, imemload, iREN, iaddr, hit_count, miss_count
    );

    // Datapath / memory-controller side
    modport master (
        output imemREN, imemaddr, flush, iwait, iload,
        input  ihit, imemload, iREN, iaddr, hit_count, miss_count
    );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with blocking miss fill,
// global flush and saturating hit/miss counters.
module icache_direct #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned WORD_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            CLK,
    input  logic            RST,
    icache_direct_if.slave  bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = WORD_W - IDX_W - 2;

    typedef enum logic {IDLE, FILL} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   miss_addr_q, miss_addr_d;
    logic                flush_pend_q, flush_pend_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q  [SETS];
    logic [WORD_W-1:0]   data_q [SETS];
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic [IDX_W-1:0]    idx_c;
    logic [TAG_W-1:0]    tag_c;
    logic [IDX_W-1:0]    fill_idx_c;
    logic                hit_c;
    logic                fill_we_c;
    logic                unused_c;

    assign idx_c      = bus.imemaddr[IDX_W+1:2];
    assign tag_c      = bus.imemaddr[WORD_W-1:IDX_W+2];
    assign fill_idx_c = miss_addr_q[IDX_W+1:2];
    assign unused_c   = ^bus.imemaddr[1:0];

    // Zero-latency hit lookup; a flush in the same cycle suppresses the hit
    assign hit_c = (state_q == IDLE) && bus.imemREN && !bus.flush &&
                   valid_q[idx_c] && (tag_q[idx_c] == tag_c);

    assign bus.ihit       = hit_c;
    assign bus.imemload   = hit_c ? data_q[idx_c] : '0;
    assign bus.iREN       = (state_q == FILL);
    assign bus.iaddr      = miss_addr_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

    // Next-state: miss detection, fill completion and flush handling
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        flush_pend_d = flush_pend_q;
        valid_d      = valid_q;
        fill_we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    valid_d = '0;
                end else if (bus.imemREN && !hit_c) begin
                    miss_addr_d = {bus.imemaddr[WORD_W-1:2], 2'b00};
                    state_d     = FILL;
                end
            end
            FILL: begin
                if (!bus.iwait) begin
                    state_d      = IDLE;
                    flush_pend_d = 1'b0;
                    if (flush_pend_q || bus.flush) begin
                        valid_d = '0;
                    end else begin
                        fill_we_c           = 1'b1;
                        valid_d[fill_idx_c] = 1'b1;
                    end
                end else if (bus.flush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating performance counters
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit_c && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + CNT_W'(1);
        end
        if ((state_q == IDLE) && (state_d == FILL) && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + CNT_W'(1);
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            miss_addr_q  <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag/data storage; no reset, and a reset edge blocks the fill write
    always_ff @(posedge CLK) begin
        if (!RST && fill_we_c) begin
            tag_q[fill_idx_c]  <= miss_addr_q[WORD_W-1:IDX_W+2];
            data_q[fill_idx_c] <= bus.iload;
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Self-checking bench for icache_direct: directed scenarios plus random traffic
// against a line-address reference model; a 4-bit-counter instance shares stimulus.
module tb_icache_direct;
    localparam int unsigned SETS = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        iwait;
    logic [31:0] iload;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-set stored word address and data
    bit          m_known = 1'b0;
    bit          m_valid [SETS];
    logic [29:0] m_line  [SETS];
    logic [31:0] m_data  [SETS];
    bit          m_busy;
    bit          m_fpend;
    logic [31:0] m_maddr;
    int          m_hits;
    int          m_miss;

    icache_direct_if #(.WORD_W(32), .CNT_W(16)) bus16 ();
    icache_direct_if #(.WORD_W(32), .CNT_W(4))  bus4 ();

    assign bus16.imemREN  = ren;
    assign bus16.imemaddr = addr;
    assign bus16.flush    = flush;
    assign bus16.iwait    = iwait;
    assign bus16.iload    = iload;
    assign bus4.imemREN   = ren;
    assign bus4.imemaddr  = addr;
    assign bus4.flush     = flush;
    assign bus4.iwait     = iwait;
    assign bus4.iload     = iload;

    icache_direct #(.SETS(SETS), .WORD_W(32), .CNT_W(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus16.slave)
    );

    icache_direct #(.SETS(SETS), .WORD_W(32), .CNT_W(4)) dut_sat (
        .CLK (clk),
        .RST (rst),
        .bus (bus4.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic bit model_hit(input logic r, input logic [31:0] a, input logic f);
        int i;
        i = int'(a[5:2]);
        return !m_busy && r && !f && m_valid[i] && (m_line[i] == a[31:2]);
    endfunction

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model
    task automatic cyc(input logic r, input logic rn, input logic [31:0] a, input logic f,
                       input logic w, input logic [31:0] ld);
        bit          eh;
        logic [31:0] el;
        int          i;
        rst = r; ren = rn; addr = a; flush = f; iwait = w; iload = ld;
        #4;
        if (m_known) begin
            eh = model_hit(rn, a, f);
            el = eh ? m_data[int'(a[5:2])] : 32'h0;
            chk("ihit",     32'(bus16.ihit),     32'(eh));
            chk("imemload", bus16.imemload,      el);
            chk("ihit4",    32'(bus4.ihit),      32'(eh));
            chk("iREN",     32'(bus16.iREN),     32'(m_busy));
            if (m_busy) chk("iaddr", bus16.iaddr, m_maddr);
            chk("hit16",    32'(bus16.hit_count),  32'(sat(m_hits, 65535)));
            chk("miss16",   32'(bus16.miss_count), 32'(sat(m_miss, 65535)));
            chk("hit4",     32'(bus4.hit_count),   32'(sat(m_hits, 15)));
            chk("miss4",    32'(bus4.miss_count),  32'(sat(m_miss, 15)));
        end else begin
            eh = 1'b0;
        end
        @(posedge clk);
        #1;
        if (r) begin
            m_known = 1'b1;
            foreach (m_valid[k]) m_valid[k] = 1'b0;
            m_busy = 0; m_fpend = 0; m_maddr = '0; m_hits = 0; m_miss = 0;
        end else if (m_known) begin
            i = int'(a[5:2]);
            if (!m_busy) begin
                if (eh) m_hits++;
                if (f) begin
                    foreach (m_valid[k]) m_valid[k] = 1'b0;
                end else if (rn && !eh) begin
                    m_maddr = {a[31:2], 2'b00};
                    m_busy  = 1;
                    m_miss++;
                end
            end else if (!w) begin
                m_busy = 0;
                if (m_fpend || f) begin
                    foreach (m_valid[k]) m_valid[k] = 1'b0;
                end else begin
                    m_valid[int'(m_maddr[5:2])] = 1'b1;
                    m_line[int'(m_maddr[5:2])]  = m_maddr[31:2];
                    m_data[int'(m_maddr[5:2])]  = ld;
                end
                m_fpend = 0;
            end else if (f) begin
                m_fpend = 1;
            end
        end
    endtask

    initial begin
        logic [31:0] ra;
        // Cold miss with three wait cycles, then hit on refetch
        cyc(1, 0, 32'h0, 0, 1, 32'h0);
        chk("rst_iren",  32'(bus16.iREN), 32'h0);
        chk("rst_iaddr", bus16.iaddr,     32'h0);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        chk("t1_iaddr", bus16.iaddr, 32'h40);
        repeat (3) cyc(0, 1, 32'h40, 0, 1, 32'hdead_beef);
        cyc(0, 1, 32'h40, 0, 0, 32'h2001_0005);
        chk("t1_load", bus16.imemload, 32'h2001_0005);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        chk("t1_miss", 32'(bus16.miss_count), 32'd1);
        chk("t1_hit",  32'(bus16.hit_count),  32'd1);

        // Conflict on set 0
        cyc(0, 1, 32'h440, 0, 1, 32'h0);
        cyc(0, 1, 32'h440, 0, 0, 32'h1111_0440);
        cyc(0, 1, 32'h40,  0, 1, 32'h0);
        chk("t2_miss", 32'(bus16.miss_count), 32'd3);
        cyc(0, 1, 32'h40,  0, 0, 32'h2001_0005);

        // Flush in IDLE, then refetch misses
        cyc(0, 1, 32'h40, 1, 1, 32'h0);
        chk("t3_miss", 32'(bus16.miss_count), 32'd3);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        chk("t3_iren", 32'(bus16.iREN), 32'h1);

        // Flush while fill pending: line not validated
        cyc(0, 1, 32'h40, 1, 1, 32'h0);
        cyc(0, 0, 32'h40, 0, 0, 32'h2001_0005);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        chk("t4_miss", 32'(bus16.miss_count), 32'd5);
        cyc(0, 1, 32'h40, 0, 0, 32'h2001_0005);

        // Redirect mid-fill
        cyc(0, 1, 32'h80, 0, 1, 32'h0);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        chk("t5_iaddr", bus16.iaddr, 32'h80);
        cyc(0, 1, 32'h40, 0, 0, 32'h0bad_0080);
        cyc(0, 1, 32'h40, 0, 1, 32'h0);
        cyc(0, 1, 32'hc0, 0, 1, 32'h0);
        cyc(0, 1, 32'hc0, 0, 0, 32'h0000_00c0);

        // Reset during a fill aborts it
        cyc(0, 1, 32'h44, 0, 1, 32'h0);
        cyc(1, 1, 32'h44, 0, 0, 32'h7777_7777);
        chk("t6_iren",  32'(bus16.iREN),       32'h0);
        chk("t6_iaddr", bus16.iaddr,           32'h0);
        chk("t6_hits",  32'(bus16.hit_count),  32'h0);
        chk("t6_miss",  32'(bus16.miss_count), 32'h0);
        cyc(0, 1, 32'h44, 0, 1, 32'h0);
        cyc(0, 1, 32'h44, 0, 0, 32'h4444_0044);
        repeat (20) cyc(0, 1, 32'h44, 0, 1, 32'h0);
        chk("t6_sat4",  32'(bus4.hit_count),  32'hf);
        chk("t6_cnt16", 32'(bus16.hit_count), 32'd20);

        // Random traffic on a small address pool to force hits and conflicts
        for (int n = 0; n < 3000; n++) begin
            ra = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            cyc(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                ra,
                ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                1'($urandom_range(0, 1)),
                $urandom());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
